param_cache: RTL and testbench

PARAM_CACHE -- requirements
Module: param_cache

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_line.sv | 55 +++++
 rtl/param_cache.sv | 158 +++++++++++++++
 tb/tb_param_cache.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared FSM state encoding and address-field width helpers for the direct-mapped cache.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2,
        ST_RESPOND   = 2'd3
    } state_t;

    function automatic int offset_width(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_bits, input int sets, input int words);
        return addr_bits - $clog2(sets) - $clog2(words);
    endfunction

endpackage

// File: rtl/cache_line.sv
// One direct-mapped line: valid/dirty/tag state (async reset) plus block storage (not reset).
// A fill replaces the whole block and cleans the line; a store updates one word and dirties it.
module cache_line #(
    parameter int WORD_SIZE = 16,
    parameter int WORDS     = 16,
    parameter int TAG_W     = 10,
    parameter int OFF_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_fill,
    input  logic [TAG_W-1:0]           i_fill_tag,
    input  logic [WORDS*WORD_SIZE-1:0] i_fill_block,
    input  logic                       i_store,
    input  logic [OFF_W-1:0]           i_store_off,
    input  logic [WORD_SIZE-1:0]       i_store_word,
    output logic                       o_valid,
    output logic                       o_dirty,
    output logic [TAG_W-1:0]           o_tag,
    output logic [WORDS*WORD_SIZE-1:0] o_block
);

    logic                            r_valid;
    logic                            r_dirty;
    logic [TAG_W-1:0]                r_tag;
    logic [WORDS-1:0][WORD_SIZE-1:0] r_block;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_dirty <= 1'b0;
            r_tag   <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_dirty <= 1'b0;
            r_tag   <= i_fill_tag;
        end else if (i_store) begin
            r_dirty <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill) begin
            r_block <= i_fill_block;
        end else if (i_store) begin
            r_block[i_store_off] <= i_store_word;
        end
    end

    assign o_valid = r_valid;
    assign o_dirty = r_dirty;
    assign o_tag   = r_tag;
    assign o_block = r_block;

endmodule

// File: rtl/param_cache.sv
// Direct-mapped write-back cache: one CPU request at a time, block fill / write-back over a
// single-cycle block_ready handshake. data_ready is a registered one-cycle pulse on leaving RESPOND.
module param_cache
    import cache_pkg::*;
#(
    parameter int NUM_OF_SETS           = 4,
    parameter int WORD_SIZE             = 16,
    parameter int NUM_OF_WORDS_IN_BLOCK = 16,
    parameter int EXTERNAL_ADDR_SIZE    = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       req_valid,
    input  logic                                       store_op,
    input  logic [EXTERNAL_ADDR_SIZE-1:0]              addr,
    input  logic [WORD_SIZE-1:0]                       incoming_word,
    output logic                                       busy,
    output logic                                       data_ready,
    output logic [WORD_SIZE-1:0]                       word,
    output logic                                       request_data,
    output logic                                       commit_valid,
    output logic [EXTERNAL_ADDR_SIZE-1:0]              requested_addr,
    output logic [WORD_SIZE*NUM_OF_WORDS_IN_BLOCK-1:0] commit_block,
    input  logic                                       block_ready,
    input  logic [WORD_SIZE*NUM_OF_WORDS_IN_BLOCK-1:0] incoming_block
);

    localparam int OFF_W = offset_width(NUM_OF_WORDS_IN_BLOCK);
    localparam int IDX_W = index_width(NUM_OF_SETS);
    localparam int TAG_W = tag_width(EXTERNAL_ADDR_SIZE, NUM_OF_SETS, NUM_OF_WORDS_IN_BLOCK);
    localparam int BLK_W = WORD_SIZE * NUM_OF_WORDS_IN_BLOCK;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_store_op;
    logic [EXTERNAL_ADDR_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0]    r_in_word;
    logic                    r_data_ready;
    logic [WORD_SIZE-1:0]    r_word;

    logic [IDX_W-1:0]        w_req_idx;
    logic [TAG_W-1:0]        w_req_tag;
    logic [OFF_W-1:0]        w_cur_off;
    logic [IDX_W-1:0]        w_cur_idx;
    logic [TAG_W-1:0]        w_cur_tag;
    logic [IDX_W-1:0]        w_sel_idx;

    logic                    w_valid [NUM_OF_SETS];
    logic                    w_dirty [NUM_OF_SETS];
    logic [TAG_W-1:0]        w_tag   [NUM_OF_SETS];
    logic [BLK_W-1:0]        w_block [NUM_OF_SETS];

    logic                    w_sel_valid;
    logic                    w_sel_dirty;
    logic [TAG_W-1:0]        w_sel_tag;
    logic [NUM_OF_WORDS_IN_BLOCK-1:0][WORD_SIZE-1:0] w_sel_words;
    logic                    w_hit;

    assign w_req_idx = addr[OFF_W +: IDX_W];
    assign w_req_tag = addr[EXTERNAL_ADDR_SIZE-1 -: TAG_W];
    assign w_cur_off = r_addr[OFF_W-1:0];
    assign w_cur_idx = r_addr[OFF_W +: IDX_W];
    assign w_cur_tag = r_addr[EXTERNAL_ADDR_SIZE-1 -: TAG_W];

    // Lookup uses the live address in IDLE, the latched one while a request is in flight.
    assign w_sel_idx   = (r_state == ST_IDLE) ? w_req_idx : w_cur_idx;
    assign w_sel_valid = w_valid[w_sel_idx];
    assign w_sel_dirty = w_dirty[w_sel_idx];
    assign w_sel_tag   = w_tag[w_sel_idx];
    assign w_sel_words = w_block[w_sel_idx];
    assign w_hit       = w_sel_valid && (w_sel_tag == w_req_tag);

    genvar g;
    generate
        for (g = 0; g < NUM_OF_SETS; g++) begin : g_line
            logic w_fill_en;
            logic w_store_en;
            assign w_fill_en  = (r_state == ST_FILL) && block_ready && (w_cur_idx == IDX_W'(g));
            assign w_store_en = (r_state == ST_RESPOND) && r_store_op && (w_cur_idx == IDX_W'(g));

            cache_line #(
                .WORD_SIZE (WORD_SIZE),
                .WORDS     (NUM_OF_WORDS_IN_BLOCK),
                .TAG_W     (TAG_W),
                .OFF_W     (OFF_W)
            ) u_line (
                .clk          (clk),
                .rst          (rst),
                .i_fill       (w_fill_en),
                .i_fill_tag   (w_cur_tag),
                .i_fill_block (incoming_block),
                .i_store      (w_store_en),
                .i_store_off  (w_cur_off),
                .i_store_word (r_in_word),
                .o_valid      (w_valid[g]),
                .o_dirty      (w_dirty[g]),
                .o_tag        (w_tag[g]),
                .o_block      (w_block[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_store_op   <= 1'b0;
            r_addr       <= '0;
            r_in_word    <= '0;
            r_data_ready <= 1'b0;
            r_word       <= '0;
        end else begin
            r_state      <= w_next;
            r_data_ready <= (r_state == ST_RESPOND);
            // Read happens before the store lands, so a store returns the old word.
            r_word       <= (r_state == ST_RESPOND) ? w_sel_words[w_cur_off] : '0;
            if (r_state == ST_IDLE && req_valid) begin
                r_store_op <= store_op;
                r_addr     <= addr;
                r_in_word  <= incoming_word;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_hit)                          w_next = ST_RESPOND;
                    else if (w_sel_valid && w_sel_dirty) w_next = ST_WRITEBACK;
                    else                                w_next = ST_FILL;
                end
            end
            ST_WRITEBACK: if (block_ready) w_next = ST_FILL;
            ST_FILL:      if (block_ready) w_next = ST_RESPOND;
            ST_RESPOND:   w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        requested_addr = '0;
        commit_block   = '0;
        if (r_state == ST_WRITEBACK) begin
            requested_addr = {w_sel_tag, w_cur_idx, {OFF_W{1'b0}}};
            commit_block   = w_sel_words;
        end else if (r_state == ST_FILL) begin
            requested_addr = {w_cur_tag, w_cur_idx, {OFF_W{1'b0}}};
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign commit_valid = (r_state == ST_WRITEBACK);
    assign request_data = (r_state == ST_FILL);
    assign data_ready   = r_data_ready;
    assign word         = r_word;

endmodule

// File: tb/tb_param_cache.sv
// Scoreboard bench: default-parameter cache plus an 8-set/4-word instance for the index sweep.
module tb_param_cache;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0, s_req_valid = 1'b0;
    logic         store_op = 1'b0;
    logic [15:0]  addr = '0;
    logic [15:0]  incoming_word = '0;
    logic         block_ready = 1'b0, s_block_ready = 1'b0;
    logic [255:0] incoming_block = '0;
    logic [63:0]  s_incoming_block = '0;

    logic         busy, data_ready, request_data, commit_valid;
    logic [15:0]  word, requested_addr;
    logic [255:0] commit_block;
    logic         s_busy, s_data_ready, s_request_data, s_commit_valid;
    logic [15:0]  s_word, s_requested_addr;
    logic [63:0]  s_commit_block;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [15:0]  exp_q[$];

    always #5 clk = ~clk;

    param_cache u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .store_op(store_op), .addr(addr),
        .incoming_word(incoming_word), .busy(busy), .data_ready(data_ready), .word(word),
        .request_data(request_data), .commit_valid(commit_valid), .requested_addr(requested_addr),
        .commit_block(commit_block), .block_ready(block_ready), .incoming_block(incoming_block)
    );

    param_cache #(.NUM_OF_SETS(8), .NUM_OF_WORDS_IN_BLOCK(4)) u_dut_s (
        .clk(clk), .rst(rst), .req_valid(s_req_valid), .store_op(store_op), .addr(addr),
        .incoming_word(incoming_word), .busy(s_busy), .data_ready(s_data_ready), .word(s_word),
        .request_data(s_request_data), .commit_valid(s_commit_valid),
        .requested_addr(s_requested_addr), .commit_block(s_commit_block),
        .block_ready(s_block_ready), .incoming_block(s_incoming_block)
    );

    // Memory image: word k of the block at base is base + 0x8000 + k.
    function automatic logic [255:0] mk_blk(input logic [15:0] base);
        logic [255:0] b;
        for (int k = 0; k < 16; k++) b[k*16 +: 16] = base + 16'h8000 + 16'(k);
        return b;
    endfunction

    task automatic issue(input bit which, input bit st, input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        store_op = st; addr = a; incoming_word = d;
        if (which) s_req_valid = 1'b1; else req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; s_req_valid = 1'b0;
    endtask

    task automatic mem_ack(input bit which, input logic [255:0] blk);
        @(posedge clk); #1;
        if (which) begin s_block_ready = 1'b1; s_incoming_block = blk[63:0]; end
        else begin block_ready = 1'b1; incoming_block = blk; end
        @(posedge clk); #1;
        block_ready = 1'b0; s_block_ready = 1'b0;
    endtask

    // Counts clock cycles (sampled on negedges) until data_ready; lat=0 means it never came.
    task automatic collect(input bit which, output int lat, output logic [15:0] w, output bit mem_seen);
        lat = 0; w = '0; mem_seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (which ? (s_request_data | s_commit_valid) : (request_data | commit_valid)) mem_seen = 1'b1;
            if (which ? s_data_ready : data_ready) begin
                lat = c; w = which ? s_word : word;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (data_ready !== 1'b0 || word !== 16'h0) begin n_fail++; $display("FAIL reset_resp: got dr=%b word=%h want 0/0000", data_ready, word); end
        n_checks++; if (request_data !== 1'b0 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem: got rd=%b cv=%b want 0/0", request_data, commit_valid); end
        n_checks++; if (requested_addr !== 16'h0 || commit_block !== '0) begin n_fail++; $display("FAIL reset_addr_blk: got addr=%h want 0000 and zero block", requested_addr); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_load_miss();
        int lat; logic [15:0] w; bit ms; logic [255:0] blk;
        blk = mk_blk(16'h0120); blk[3*16 +: 16] = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        issue(0, 0, 16'h0123, 16'h0);
        @(negedge clk);
        n_checks++; if (request_data !== 1'b1 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL miss_fill_req: got rd=%b cv=%b want 1/0", request_data, commit_valid); end
        n_checks++; if (requested_addr !== 16'h0120) begin n_fail++; $display("FAIL miss_fill_addr: got %h want 0120", requested_addr); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL miss_busy: got %b want 1", busy); end
        mem_ack(0, blk);
        collect(0, lat, w, ms);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL miss_latency: got %0d want 2 cycles after block_ready", lat); end
        n_checks++; if (w !== exp_q.pop_front()) begin n_fail++; $display("FAIL miss_word: got %h want beef", w); end
        @(negedge clk);
        n_checks++; if (data_ready !== 1'b0 || word !== 16'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL miss_pulse_end: got dr=%b word=%h busy=%b want 0/0000/0", data_ready, word, busy); end
    endtask

    task automatic test_load_hit();
        int lat; logic [15:0] w; bit ms;
        exp_q.push_back(16'hBEEF);
        issue(0, 0, 16'h0123, 16'h0);
        collect(0, lat, w, ms);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL hit_latency: got %0d want 2", lat); end
        n_checks++; if (ms !== 1'b0) begin n_fail++; $display("FAIL hit_no_mem: got mem activity %b want 0", ms); end
        n_checks++; if (w !== exp_q.pop_front()) begin n_fail++; $display("FAIL hit_word: got %h want beef", w); end
    endtask

    task automatic test_store_writeback();
        int lat; logic [15:0] w; bit ms;
        exp_q.push_back(16'h8125);
        issue(0, 1, 16'h0125, 16'h1234);
        collect(0, lat, w, ms);
        n_checks++; if (lat !== 2 || ms !== 1'b0) begin n_fail++; $display("FAIL store_hit: got lat=%0d mem=%b want 2/0", lat, ms); end
        n_checks++; if (w !== exp_q.pop_front()) begin n_fail++; $display("FAIL store_old_word: got %h want 8125", w); end
        exp_q.push_back(16'h9125);
        issue(0, 0, 16'h1125, 16'h0);
        @(negedge clk);
        n_checks++; if (commit_valid !== 1'b1 || request_data !== 1'b0) begin n_fail++; $display("FAIL wb_valid: got cv=%b rd=%b want 1/0", commit_valid, request_data); end
        n_checks++; if (requested_addr !== 16'h0120) begin n_fail++; $display("FAIL wb_addr: got %h want 0120", requested_addr); end
        n_checks++; if (commit_block[5*16 +: 16] !== 16'h1234 || commit_block[3*16 +: 16] !== 16'hBEEF) begin n_fail++; $display("FAIL wb_block: got w5=%h w3=%h want 1234/beef", commit_block[5*16 +: 16], commit_block[3*16 +: 16]); end
        mem_ack(0, '0);
        @(negedge clk);
        n_checks++; if (request_data !== 1'b1 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL wb_then_fill: got rd=%b cv=%b want 1/0", request_data, commit_valid); end
        n_checks++; if (requested_addr !== 16'h1120) begin n_fail++; $display("FAIL wb_fill_addr: got %h want 1120", requested_addr); end
        mem_ack(0, mk_blk(16'h1120));
        collect(0, lat, w, ms);
        n_checks++; if (lat !== 2 || w !== exp_q.pop_front()) begin n_fail++; $display("FAIL wb_load_word: got lat=%0d word=%h want 2/9125", lat, w); end
    endtask

    task automatic test_busy_ignore();
        int lat; logic [15:0] w; bit ms; int extra;
        exp_q.push_back(16'hA000);
        issue(0, 0, 16'h2000, 16'h0);
        @(negedge clk); req_valid = 1'b1; addr = 16'h0040;
        @(negedge clk);
        n_checks++; if (requested_addr !== 16'h2000 || busy !== 1'b1) begin n_fail++; $display("FAIL busy_fill_kept: got addr=%h busy=%b want 2000/1", requested_addr, busy); end
        req_valid = 1'b0;
        mem_ack(0, mk_blk(16'h2000));
        collect(0, lat, w, ms);
        n_checks++; if (lat !== 2 || w !== exp_q.pop_front()) begin n_fail++; $display("FAIL busy_word: got lat=%0d word=%h want 2/a000", lat, w); end
        extra = 0;
        for (int c = 0; c < 6; c++) begin @(negedge clk); if (data_ready || busy) extra++; end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL busy_ignored: got %0d extra busy/data_ready cycles want 0", extra); end
    endtask

    task automatic test_reset_mid_fill();
        int lat; logic [15:0] w; bit ms;
        issue(0, 0, 16'h0123, 16'h0);
        @(negedge clk);
        n_checks++; if (request_data !== 1'b1) begin n_fail++; $display("FAIL rst_pre_fill: got %b want 1", request_data); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (request_data !== 1'b0 || busy !== 1'b0 || requested_addr !== 16'h0 || commit_valid !== 1'b0 || data_ready !== 1'b0 || word !== 16'h0) begin n_fail++; $display("FAIL rst_async: got rd=%b busy=%b addr=%h cv=%b dr=%b word=%h want all 0", request_data, busy, requested_addr, commit_valid, data_ready, word); end
        @(negedge clk); rst = 1'b1;
        exp_q.push_back(16'h8123);
        issue(0, 0, 16'h0123, 16'h0);
        @(negedge clk);
        n_checks++; if (request_data !== 1'b1 || requested_addr !== 16'h0120) begin n_fail++; $display("FAIL rst_remiss: got rd=%b addr=%h want 1/0120", request_data, requested_addr); end
        mem_ack(0, mk_blk(16'h0120));
        collect(0, lat, w, ms);
        n_checks++; if (lat !== 2 || w !== exp_q.pop_front()) begin n_fail++; $display("FAIL rst_reload: got lat=%0d word=%h want 2/8123", lat, w); end
    endtask

    task automatic test_param_sweep();
        int lat; logic [15:0] w; bit ms;
        logic [15:0] la[3];
        logic [15:0] fa[3];
        la = '{16'h001F, 16'h000D, 16'h003D};
        fa = '{16'h001C, 16'h000C, 16'h003C};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(la[i] + 16'h8000);
            issue(1, 0, la[i], 16'h0);
            @(negedge clk);
            n_checks++; if (s_request_data !== 1'b1 || s_requested_addr !== fa[i]) begin n_fail++; $display("FAIL sweep_fill_%0d: got rd=%b addr=%h want 1/%h", i, s_request_data, s_requested_addr, fa[i]); end
            mem_ack(1, mk_blk(fa[i]));
            collect(1, lat, w, ms);
            n_checks++; if (lat !== 2 || w !== exp_q.pop_front()) begin n_fail++; $display("FAIL sweep_word_%0d: got lat=%0d word=%h want 2/%h", i, lat, w, la[i] + 16'h8000); end
        end
        exp_q.push_back(16'h800E);
        issue(1, 0, 16'h000E, 16'h0);
        collect(1, lat, w, ms);
        n_checks++; if (lat !== 2 || ms !== 1'b0 || w !== exp_q.pop_front()) begin n_fail++; $display("FAIL sweep_hit: got lat=%0d mem=%b word=%h want 2/0/800e", lat, ms, w); end
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store_writeback();
        test_busy_ignore();
        test_reset_mid_fill();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
